// File: rtl/sap_pkg.sv
// Shared definitions for the SAP register bank: operation codes and the
// swap-sequencer state encoding.
package sap_pkg;

  // Control-word operation field of the register bank
  typedef enum logic [2:0] {
    REG_NOP  = 3'd0,
    REG_INR  = 3'd1,
    REG_DCR  = 3'd2,
    REG_SHL  = 3'd3,
    REG_SHR  = 3'd4,
    REG_SWAP = 3'd5,
    REG_CLRR = 3'd6
  } reg_op_t;

  // Two-register swap sequence
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_FILL = 2'd2
  } swap_state_t;

endpackage

// File: rtl/sap_register_bank_if.sv
// Control-word / W-bus connection between the controller-sequencer (master)
// and the register bank (slave).
interface sap_register_bank_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic             Lr_bar;
  logic             Er_bar;
  logic [2:0]       op;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_b;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             bus_oe;
  logic             busy;
  logic             zero;
  logic             sign;
  logic             carry;

  modport master (
    output Lr_bar, Er_bar, op, sel, sel_b, data_in,
    input  data_out, bus_oe, busy, zero, sign, carry
  );

  modport slave (
    input  Lr_bar, Er_bar, op, sel, sel_b, data_in,
    output data_out, bus_oe, busy, zero, sign, carry
  );
endinterface

// File: rtl/sap_reg_alu.sv
// Combinational single-cycle operation unit of the register bank.
// Shift operations exist only when SAP_REG_SHIFT_EN is defined; otherwise
// SHL/SHR decode as NOP (valid stays low).
module sap_reg_alu
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  reg_op_t          op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             valid
);

  // Compute result and carry; valid marks ops that write the register and flags
  always_comb begin
    result = operand;
    carry  = 1'b0;
    valid  = 1'b0;
    case (op)
      REG_INR: begin
        {carry, result} = {1'b0, operand} + {{WIDTH{1'b0}}, 1'b1};
        valid           = 1'b1;
      end
      REG_DCR: begin
        // borrow appears in the extra top bit when wrapping 0 -> all-ones
        {carry, result} = {1'b0, operand} - {{WIDTH{1'b0}}, 1'b1};
        valid           = 1'b1;
      end
`ifdef SAP_REG_SHIFT_EN
      REG_SHL: begin
        result = {operand[WIDTH-2:0], 1'b0};
        carry  = operand[WIDTH-1];
        valid  = 1'b1;
      end
      REG_SHR: begin
        result = {1'b0, operand[WIDTH-1:1]};
        carry  = operand[0];
        valid  = 1'b1;
      end
`endif
      REG_CLRR: begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        valid  = 1'b1;
      end
      default: begin
        result = operand;
        carry  = 1'b0;
        valid  = 1'b0;
      end
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});
  assign sign = result[WIDTH-1];

endmodule

// File: rtl/sap_register_bank.sv
// SAP general register bank: NUM_REGS registers loaded from the W bus,
// single-cycle INR/DCR/SHL/SHR/CLRR, and a three-state sequenced SWAP.
// Optional feature macro: SAP_REG_SHIFT_EN (enables SHL/SHR in sap_reg_alu).
module sap_register_bank
  import sap_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                 CLK,
  input  logic                 CLR_bar,
  sap_register_bank_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam logic [SEL_W:0] NUM_REGS_V = (SEL_W + 1)'(NUM_REGS);

  logic [WIDTH-1:0] regs_r [NUM_REGS];
  logic [WIDTH-1:0] tmp_r;
  logic [SEL_W-1:0] a_r;
  logic [SEL_W-1:0] b_r;
  swap_state_t      state_r;
  logic             zero_r;
  logic             sign_r;
  logic             carry_r;

  logic             sel_ok_s;
  logic             sel_b_ok_s;
  logic             idle_s;
  logic             do_load_s;
  logic             do_op_s;
  logic             do_swap_s;
  reg_op_t          op_s;
  logic [WIDTH-1:0] operand_s;
  logic [WIDTH-1:0] result_s;
  logic             alu_zero_s;
  logic             alu_sign_s;
  logic             alu_carry_s;
  logic             alu_valid_s;

  // Selects beyond NUM_REGS exist only when NUM_REGS is not a power of two
  assign sel_ok_s   = ({1'b0, bus.sel}   < NUM_REGS_V);
  assign sel_b_ok_s = ({1'b0, bus.sel_b} < NUM_REGS_V);
  assign op_s       = reg_op_t'(bus.op);
  assign idle_s     = (state_r == S_IDLE);

  // Read the selected register; out-of-range selects read as zero
  always_comb begin
    if (sel_ok_s) begin
      operand_s = regs_r[bus.sel];
    end else begin
      operand_s = {WIDTH{1'b0}};
    end
  end

  sap_reg_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (op_s),
    .operand (operand_s),
    .result  (result_s),
    .zero    (alu_zero_s),
    .sign    (alu_sign_s),
    .carry   (alu_carry_s),
    .valid   (alu_valid_s)
  );

  // Command decode: commands only in IDLE, load beats any op in the same cycle
  assign do_load_s = idle_s & ~bus.Lr_bar & sel_ok_s;
  assign do_op_s   = idle_s &  bus.Lr_bar & sel_ok_s & alu_valid_s;
  assign do_swap_s = idle_s &  bus.Lr_bar & sel_ok_s & sel_b_ok_s & (op_s == REG_SWAP);

  // Swap sequencer: capture operands and R[sel] on acceptance, then MOVE, FILL
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_r <= S_IDLE;
      tmp_r   <= {WIDTH{1'b0}};
      a_r     <= {SEL_W{1'b0}};
      b_r     <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (do_swap_s) begin
            tmp_r   <= operand_s;
            a_r     <= bus.sel;
            b_r     <= bus.sel_b;
            state_r <= S_MOVE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MOVE:  state_r <= S_FILL;
        S_FILL:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Register array writes: load / single-cycle op in IDLE, swap moves otherwise
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (do_load_s) begin
            regs_r[bus.sel] <= bus.data_in;
          end else if (do_op_s) begin
            regs_r[bus.sel] <= result_s;
          end else begin
            regs_r[0] <= regs_r[0];
          end
        end
        S_MOVE:  regs_r[a_r] <= regs_r[b_r];
        S_FILL:  regs_r[b_r] <= tmp_r;
        default: regs_r[0]   <= regs_r[0];
      endcase
    end
  end

  // Flags follow only the arithmetic/shift/clear ops
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      zero_r  <= 1'b0;
      sign_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (do_op_s) begin
      zero_r  <= alu_zero_s;
      sign_r  <= alu_sign_s;
      carry_r <= alu_carry_s;
    end else begin
      zero_r  <= zero_r;
      sign_r  <= sign_r;
      carry_r <= carry_r;
    end
  end

  assign bus.data_out = operand_s;
  assign bus.busy     = ~idle_s;
  assign bus.bus_oe   = ~bus.Er_bar & idle_s;
  assign bus.zero     = zero_r;
  assign bus.sign     = sign_r;
  assign bus.carry    = carry_r;

endmodule

// File: doc/sap_register_bank.md
# sap_register_bank

Parametrised multi-register successor to the single 8-bit B register of the SAP datapath. It holds NUM_REGS general registers (B, C, temp, …) that load from the W bus and present a selected register to it. It also executes single-cycle increment, decrement, shift and clear operations and a sequenced two-register swap. It sits beside the accumulator/ALU and is driven by the controller-sequencer's control word.

## Interface
- WIDTH, 8, register and bus width (≥2)
- NUM_REGS, 4, number of registers (≥2); localparam SEL_W = $clog2(NUM_REGS)
- CLK  input  1  clock, all state updates on rising edge
- CLR_bar  input  1  reset, asynchronous, active-low
- Lr_bar  input  1  load R[sel] from data_in, active-low
- Er_bar  input  1  request to drive R[sel] onto W bus, active-low
- op  input  3  operation code (see Operation)
- sel  input  SEL_W  primary register select
- sel_b  input  SEL_W  second operand, SWAP only
- data_in  input  WIDTH  W bus input
- data_out  output  WIDTH  R[sel], combinational
- bus_oe  output  1  = ~Er_bar & ~busy; tri-state enable for the bus driver
- busy  output  1  swap sequence in progress
- zero, sign, carry  output  1 each  registered flags of the last arithmetic/shift op

## Operation
- op codes: 000 NOP, 001 INR, 010 DCR, 011 SHL, 100 SHR, 101 SWAP, 110 CLRR, 111 NOP (reserved).
- Commands (Lr_bar, op) are sampled only in IDLE. While busy they are ignored entirely.
- Priority in one IDLE cycle: Lr_bar low wins; op is discarded that cycle.
- Load: R[sel] ← data_in; flags unchanged.
- INR: R[sel] ← R[sel]+1 mod 2^WIDTH; carry = 1 on all-ones → 0.
- DCR: R[sel] ← R[sel]−1 mod 2^WIDTH; carry (borrow) = 1 on 0 → all-ones.
- SHL: R ← {R[WIDTH-2:0],0}; carry = old MSB. SHR (logical): R ← {0,R[WIDTH-1:1]}; carry = old LSB.
- CLRR: R[sel] ← 0; zero=1, sign=0, carry=0.
- For INR/DCR/SHL/SHR: zero = (result==0), sign = result MSB. Flags are unchanged by load, SWAP and NOP.
- Out-of-range sel/sel_b (NUM_REGS not a power of 2):
  - loads and ops are ignored;
  - data_out = 0.
- SWAP FSM, states S_IDLE, S_MOVE, S_FILL:
  - S_IDLE, op=SWAP accepted: tmp ← R[sel]; latch a=sel, b=sel_b → S_MOVE.
  - S_MOVE: R[a] ← R[b] → S_FILL.
  - S_FILL: R[b] ← tmp → S_IDLE.
  - a==b still runs the full sequence, with no net change.
- Reset (any time, including mid-swap):
  - all R, tmp and flags = 0;
  - state = S_IDLE, busy = 0;
  - data_out = 0, bus_oe = ~Er_bar.

## Timing
- Load/INR/DCR/SHL/SHR/CLRR: result visible on data_out and flags one cycle after the sampling edge (latency 1).
- SWAP: busy high for exactly 2 cycles (S_MOVE, S_FILL), starting the cycle after acceptance. Both registers hold swapped values after the S_FILL edge. A new command can be accepted on the first edge with busy low.
- data_out follows sel combinationally. During busy it shows live register contents, which may be intermediate; bus_oe is forced low.
- Back-to-back single-cycle ops on consecutive cycles are legal, with no bubble.

## Configuration
- SAP_REG_SHIFT_EN defined: SHL/SHR behave as above.
- Not defined: op 011/100 decode as NOP (no register or flag change) and the shift logic is not synthesised.

## Structure
- Shared package sap_pkg:
  - typedef enum logic [2:0] reg_op_t (REG_NOP, REG_INR, REG_DCR, REG_SHL, REG_SHR, REG_SWAP, REG_CLRR);
  - typedef enum swap_state_t (S_IDLE, S_MOVE, S_FILL).
- One sub-module, sap_reg_alu: combinational op/operand → result, zero, sign, carry. It contains the shift path under SAP_REG_SHIFT_EN. The top keeps the register array, tmp, FSM and flag registers.

## Test plan
- Reset then load R0=8'h3C, R1=8'hA5 → data_out with sel=0 shows 3C and with sel=1 shows A5. Flags stay 0.
- R2=8'hFF, INR → R2=00, zero=1, carry=1, sign=0. Then DCR → R2=FF, carry=1, sign=1, zero=0.
- R0=8'h81, SHL → 02, carry=1; SHR → 01, carry=0.
  - Build without SAP_REG_SHIFT_EN: R0 stays 81 and flags are unchanged.
- R0=3C, R1=A5, SWAP sel=0 sel_b=1 → busy=1 for 2 cycles, bus_oe=0 with Er_bar low. Final R0=A5, R1=3C. An INR issued during busy is ignored.
- Lr_bar low and op=INR in the same cycle on R3=10, data_in=55 → R3=55, flags unchanged.
- Start SWAP, assert CLR_bar low during S_MOVE → all registers 0, busy=0 immediately, and the next SWAP works normally.
